// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, control
// field values, FSM state codes and the instruction classes the decoder
// reports.
package mc_ctrl_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    // ALUCtr
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;

    // EXTCtr
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    // nPCSel
    localparam logic [2:0] NPC_PC4  = 3'd0;
    localparam logic [2:0] NPC_BEQ  = 3'd1;
    localparam logic [2:0] NPC_JUMP = 3'd2;
    localparam logic [2:0] NPC_JREG = 3'd3;
    localparam logic [2:0] NPC_BNE  = 3'd4;

    // RegWriteCtr
    localparam logic [1:0] RWC_ALU = 2'd0;
    localparam logic [1:0] RWC_DM  = 2'd1;
    localparam logic [1:0] RWC_PC4 = 2'd2;

    // RegSel
    localparam logic [1:0] RSEL_RT = 2'd0;
    localparam logic [1:0] RSEL_RD = 2'd1;
    localparam logic [1:0] RSEL_RA = 2'd2;

    // FSM states
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    typedef enum logic [3:0] {
        RTYPE_ALU,
        ITYPE_ALU,
        LOAD,
        STORE,
        BRANCH,
        JUMP,
        JLINK,
        JREG,
        JRLINK,
        ILLEGAL
    } instr_class_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: classifies op/func and produces the
// ALU/extender settings and width selects that stay fixed for the whole
// instruction.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   func,
    output instr_class_e iclass,
    output logic [3:0]   alu_ctr,
    output logic [1:0]   ext_ctr,
    output logic         sel_a,
    output logic         sel_b,
    output logic         byte_op,
    output logic         is_bne
);

    // Classify the instruction and pick its datapath settings
    always_comb begin
        iclass  = ILLEGAL;
        alu_ctr = ALU_ADD;
        ext_ctr = EXT_ZERO;
        sel_a   = 1'b0;
        sel_b   = 1'b0;
        byte_op = 1'b0;
        is_bne  = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADDU: iclass = RTYPE_ALU;
                    FN_SUBU: begin
                        iclass  = RTYPE_ALU;
                        alu_ctr = ALU_SUB;
                    end
                    FN_SLL: begin
                        iclass  = RTYPE_ALU;
                        alu_ctr = ALU_SLL;
                        sel_a   = 1'b1;
                    end
                    FN_JR:   iclass = JREG;
                    FN_JALR: iclass = JRLINK;
                    default: iclass = ILLEGAL;
                endcase
            end
            OP_ORI: begin
                iclass  = ITYPE_ALU;
                alu_ctr = ALU_OR;
                sel_b   = 1'b1;
            end
            OP_LUI: begin
                iclass  = ITYPE_ALU;
                ext_ctr = EXT_LUI;
                sel_b   = 1'b1;
            end
            OP_LW, OP_LB: begin
                iclass  = LOAD;
                ext_ctr = EXT_SIGN;
                sel_b   = 1'b1;
                byte_op = (op == OP_LB);
            end
            OP_SW, OP_SB: begin
                iclass  = STORE;
                ext_ctr = EXT_SIGN;
                sel_b   = 1'b1;
                byte_op = (op == OP_SB);
            end
            OP_BEQ, OP_BNE: begin
                iclass  = BRANCH;
                alu_ctr = ALU_SUB;
                is_bne  = (op == OP_BNE);
            end
            OP_J:    iclass = JUMP;
            OP_JAL:  iclass = JLINK;
            default: iclass = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS datapath. Sequences each instruction
// through FETCH/DECODE/EXEC/MEM/WB, raises PCWr only in the retiring cycle
// and counts retired instructions.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [5:0]           op,
    input  logic [5:0]           func,
    input  logic                 Zero,
    output logic                 PCWr,
    output logic                 IRWr,
    output logic                 RegWrite,
    output logic [1:0]           RegWriteCtr,
    output logic [1:0]           RegSel,
    output logic                 ALUSelA,
    output logic                 ALUSelB,
    output logic [3:0]           ALUCtr,
    output logic                 MemWrite,
    output logic [1:0]           MemWriteCtr,
    output logic [2:0]           MemOutCtr,
    output logic [1:0]           EXTCtr,
    output logic [2:0]           nPCSel,
    output logic                 InstrDone,
    output logic [CNT_WIDTH-1:0] RetiredCnt
);

    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [5:0]           op_lat;
    logic [5:0]           func_lat;
    logic [CNT_WIDTH-1:0] cnt;

    logic [5:0]   dec_op;
    logic [5:0]   dec_func;
    instr_class_e iclass;
    logic [3:0]   dec_alu;
    logic [1:0]   dec_ext;
    logic         dec_sel_a;
    logic         dec_sel_b;
    logic         dec_byte;
    logic         dec_bne;

    logic pc_wr;
    logic ir_wr;
    logic reg_write;
    logic mem_write;

    // The branch outcome is resolved by the datapath's next-PC logic
    logic unused_zero;
    assign unused_zero = Zero;

    // DECODE looks at the live IR fields; later states use the latched copy
    assign dec_op   = (state == ST_DECODE) ? op   : op_lat;
    assign dec_func = (state == ST_DECODE) ? func : func_lat;

    mc_ctrl_decode u_decode (
        .op      (dec_op),
        .func    (dec_func),
        .iclass  (iclass),
        .alu_ctr (dec_alu),
        .ext_ctr (dec_ext),
        .sel_a   (dec_sel_a),
        .sel_b   (dec_sel_b),
        .byte_op (dec_byte),
        .is_bne  (dec_bne)
    );

    // Next-state and per-state control outputs
    always_comb begin
        state_next  = state;
        pc_wr       = 1'b0;
        ir_wr       = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        RegWriteCtr = RWC_ALU;
        RegSel      = RSEL_RT;
        ALUSelA     = 1'b0;
        ALUSelB     = 1'b0;
        ALUCtr      = ALU_ADD;
        MemWriteCtr = 2'd0;
        MemOutCtr   = 3'd0;
        EXTCtr      = EXT_ZERO;
        nPCSel      = NPC_PC4;
        case (state)
            ST_FETCH: begin
                ir_wr      = 1'b1;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (iclass == ILLEGAL) begin
                    // Unsupported encodings retire as a NOP
                    pc_wr      = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ALUSelA = dec_sel_a;
                ALUSelB = dec_sel_b;
                ALUCtr  = dec_alu;
                EXTCtr  = dec_ext;
                state_next = ST_FETCH;
                case (iclass)
                    RTYPE_ALU, ITYPE_ALU: state_next = ST_WB;
                    LOAD, STORE:          state_next = ST_MEM;
                    BRANCH: begin
                        pc_wr  = 1'b1;
                        nPCSel = dec_bne ? NPC_BNE : NPC_BEQ;
                    end
                    JUMP: begin
                        pc_wr  = 1'b1;
                        nPCSel = NPC_JUMP;
                    end
                    JLINK: begin
                        pc_wr       = 1'b1;
                        nPCSel      = NPC_JUMP;
                        reg_write   = 1'b1;
                        RegSel      = RSEL_RA;
                        RegWriteCtr = RWC_PC4;
                    end
                    JREG: begin
                        pc_wr  = 1'b1;
                        nPCSel = NPC_JREG;
                    end
                    JRLINK: begin
                        pc_wr       = 1'b1;
                        nPCSel      = NPC_JREG;
                        reg_write   = 1'b1;
                        RegSel      = RSEL_RD;
                        RegWriteCtr = RWC_PC4;
                    end
                    default: state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                // Address comes straight off the ALU, so keep it steady
                ALUSelA = dec_sel_a;
                ALUSelB = dec_sel_b;
                ALUCtr  = dec_alu;
                EXTCtr  = dec_ext;
                if (iclass == STORE) begin
                    mem_write   = 1'b1;
                    MemWriteCtr = {1'b0, dec_byte};
                    pc_wr       = 1'b1;
                    state_next  = ST_FETCH;
                end else begin
                    MemOutCtr  = {2'b00, dec_byte};
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                // ALU/address path held so the write-back data stays valid
                ALUSelA   = dec_sel_a;
                ALUSelB   = dec_sel_b;
                ALUCtr    = dec_alu;
                EXTCtr    = dec_ext;
                reg_write = 1'b1;
                pc_wr     = 1'b1;
                if (iclass == LOAD) begin
                    RegWriteCtr = RWC_DM;
                    MemOutCtr   = {2'b00, dec_byte};
                end else begin
                    RegSel = (iclass == RTYPE_ALU) ? RSEL_RD : RSEL_RT;
                end
                state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    // Reset gates every enable so nothing is written in a reset cycle
    assign PCWr       = pc_wr & ~Rst;
    assign IRWr       = ir_wr & ~Rst;
    assign RegWrite   = reg_write & ~Rst;
    assign MemWrite   = mem_write & ~Rst;
    assign InstrDone  = PCWr;
    assign RetiredCnt = cnt;

    // State register, op/func latch and retired-instruction counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_FETCH;
            op_lat   <= 6'd0;
            func_lat <= 6'd0;
            cnt      <= '0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                op_lat   <= op;
                func_lat <= func;
            end
            if (pc_wr) begin
                cnt <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each instruction issued pushes its expected
// per-cycle control vectors; a negedge monitor pops and compares them.
module tb_mc_ctrl;

    localparam int CW = 4;

    logic          Clk;
    logic          Rst;
    logic [5:0]    op;
    logic [5:0]    func;
    logic          Zero;
    logic          PCWr;
    logic          IRWr;
    logic          RegWrite;
    logic [1:0]    RegWriteCtr;
    logic [1:0]    RegSel;
    logic          ALUSelA;
    logic          ALUSelB;
    logic [3:0]    ALUCtr;
    logic          MemWrite;
    logic [1:0]    MemWriteCtr;
    logic [2:0]    MemOutCtr;
    logic [1:0]    EXTCtr;
    logic [2:0]    nPCSel;
    logic          InstrDone;
    logic [CW-1:0] RetiredCnt;

    mc_ctrl #(.CNT_WIDTH(CW)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .op          (op),
        .func        (func),
        .Zero        (Zero),
        .PCWr        (PCWr),
        .IRWr        (IRWr),
        .RegWrite    (RegWrite),
        .RegWriteCtr (RegWriteCtr),
        .RegSel      (RegSel),
        .ALUSelA     (ALUSelA),
        .ALUSelB     (ALUSelB),
        .ALUCtr      (ALUCtr),
        .MemWrite    (MemWrite),
        .MemWriteCtr (MemWriteCtr),
        .MemOutCtr   (MemOutCtr),
        .EXTCtr      (EXTCtr),
        .nPCSel      (nPCSel),
        .InstrDone   (InstrDone),
        .RetiredCnt  (RetiredCnt)
    );

    typedef struct packed {
        logic          pcwr;
        logic          irwr;
        logic          rw;
        logic          mw;
        logic          done;
        logic [1:0]    rwc;
        logic [1:0]    rsel;
        logic          sa;
        logic          sb;
        logic [3:0]    alu;
        logic [1:0]    mwc;
        logic [2:0]    moc;
        logic [1:0]    ext;
        logic [2:0]    npc;
        logic [CW-1:0] cnt;
    } outv_t;

    typedef struct {
        outv_t      v;
        outv_t      m;
        logic [5:0] op;
        int         stage;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   mcnt  = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic exp_t mkx(input outv_t v, input outv_t m, input logic [5:0] o,
                                 input int st);
        exp_t r;
        r.v      = v;
        r.v.done = v.pcwr;
        r.m      = m;
        r.op     = o;
        r.stage  = st;
        return r;
    endfunction

    // Reference model: expected control vectors for one instruction, built
    // from the instruction's class and its documented per-phase behaviour.
    task automatic push_instr(input logic [5:0] iop, input logic [5:0] ifn,
                              input int rst_at, output int len);
        exp_t       cyc[$];
        outv_t      base, ab, e, all, noalu, en;
        logic       sa, sb, bop;
        logic [3:0] alu;
        logic [1:0] ext;
        int         kind; // 0 R-alu 1 I-alu 2 load 3 store 4 beq 5 bne 6 j 7 jal 8 jr 9 jalr 10 bad
        sa = 1'b0; sb = 1'b0; bop = 1'b0; alu = 4'd0; ext = 2'd0; kind = 10;
        case (iop)
            6'h00: case (ifn)
                6'h21:   kind = 0;
                6'h23:   begin kind = 0; alu = 4'd1; end
                6'h00:   begin kind = 0; alu = 4'd3; sa = 1'b1; end
                6'h08:   kind = 8;
                6'h09:   kind = 9;
                default: kind = 10;
            endcase
            6'h0d:   begin kind = 1; sb = 1'b1; alu = 4'd2; end
            6'h0f:   begin kind = 1; sb = 1'b1; ext = 2'd2; end
            6'h23:   begin kind = 2; sb = 1'b1; ext = 2'd1; end
            6'h20:   begin kind = 2; sb = 1'b1; ext = 2'd1; bop = 1'b1; end
            6'h2b:   begin kind = 3; sb = 1'b1; ext = 2'd1; end
            6'h28:   begin kind = 3; sb = 1'b1; ext = 2'd1; bop = 1'b1; end
            6'h04:   begin kind = 4; alu = 4'd1; end
            6'h05:   begin kind = 5; alu = 4'd1; end
            6'h02:   kind = 6;
            6'h03:   kind = 7;
            default: kind = 10;
        endcase
        all   = '1;
        noalu = '1;
        noalu.sa = 1'b0; noalu.sb = 1'b0; noalu.alu = 4'd0; noalu.ext = 2'd0;
        en    = '0;
        en.pcwr = 1'b1; en.irwr = 1'b1; en.rw = 1'b1; en.mw = 1'b1; en.done = 1'b1;
        base = '0;
        base.cnt = CW'(mcnt);
        ab = base;
        ab.sa = sa; ab.sb = sb; ab.alu = alu; ab.ext = ext;

        e = base; e.irwr = 1'b1;
        cyc.push_back(mkx(e, all, iop, 0));
        e = base;
        if (kind == 10) e.pcwr = 1'b1;
        cyc.push_back(mkx(e, all, iop, 1));
        if (kind != 10) begin
            e = ab;
            case (kind)
                4: begin e.pcwr = 1'b1; e.npc = 3'd1; end
                5: begin e.pcwr = 1'b1; e.npc = 3'd4; end
                6: begin e.pcwr = 1'b1; e.npc = 3'd2; end
                7: begin e.pcwr = 1'b1; e.npc = 3'd2; e.rw = 1'b1; e.rsel = 2'd2; e.rwc = 2'd2; end
                8: begin e.pcwr = 1'b1; e.npc = 3'd3; end
                9: begin e.pcwr = 1'b1; e.npc = 3'd3; e.rw = 1'b1; e.rsel = 2'd1; e.rwc = 2'd2; end
                default: ;
            endcase
            cyc.push_back(mkx(e, all, iop, 2));
            if (kind == 2 || kind == 3) begin
                e = ab;
                if (kind == 3) begin
                    e.mw = 1'b1; e.mwc = {1'b0, bop}; e.pcwr = 1'b1;
                end else begin
                    e.moc = {2'b00, bop};
                end
                cyc.push_back(mkx(e, all, iop, 3));
            end
            if (kind <= 2) begin
                e = ab;
                e.rw = 1'b1; e.pcwr = 1'b1;
                if (kind == 2) begin
                    e.rwc = 2'd1; e.moc = {2'b00, bop};
                end else begin
                    e.rsel = (kind == 0) ? 2'd1 : 2'd0;
                end
                cyc.push_back(mkx(e, noalu, iop, 4));
            end
        end
        len = cyc.size();
        if (rst_at >= 0 && rst_at < len) begin
            for (int i = 0; i < rst_at; i++) q.push_back(cyc[i]);
            q.push_back(mkx('0, en, iop, 9));
            mcnt = 0;
            len  = rst_at + 1;
        end else begin
            for (int i = 0; i < len; i++) q.push_back(cyc[i]);
            mcnt = (mcnt + 1) % (1 << CW);
        end
    endtask

    // Drive one instruction; IR fields are only meaningful in DECODE
    task automatic run(input logic [5:0] iop, input logic [5:0] ifn, input int zmode,
                       input int rst_at);
        int len;
        push_instr(iop, ifn, rst_at, len);
        for (int c = 0; c < len; c++) begin
            op   = (c == 1) ? iop : 6'($urandom);
            func = (c == 1) ? ifn : 6'($urandom);
            Zero = (zmode < 0) ? 1'($urandom) : (zmode != 0);
            Rst  = (c == rst_at);
            @(posedge Clk);
            #1;
        end
        Rst = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the scoreboard mid-cycle
    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t  x;
            outv_t act;
            x   = q.pop_front();
            act = {PCWr, IRWr, RegWrite, MemWrite, InstrDone, RegWriteCtr, RegSel, ALUSelA,
                   ALUSelB, ALUCtr, MemWriteCtr, MemOutCtr, EXTCtr, nPCSel, RetiredCnt};
            total++;
            if (((act ^ x.v) & x.m) !== '0) begin
                bad++;
                $display("FAIL ctl op=%h stage=%0d got=%h required=%h mask=%h",
                         x.op, x.stage, act, x.v, x.m);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [5:0] top_t [15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23,
                               6'h20, 6'h2b, 6'h28, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] tfn_t [15] = '{6'h21, 6'h23, 6'h00, 6'h08, 6'h09, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        Rst  = 1'b1;
        op   = 6'h0d;
        func = 6'h00;
        Zero = 1'b0;
        @(posedge Clk);
        #1;
        // Two reset cycles: every enable must be low
        begin
            outv_t en;
            en = '0;
            en.pcwr = 1'b1; en.irwr = 1'b1; en.rw = 1'b1; en.mw = 1'b1; en.done = 1'b1;
            q.push_back(mkx('0, en, 6'h00, 9));
            q.push_back(mkx('0, en, 6'h00, 9));
        end
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
        Rst  = 1'b0;
        mcnt = 0;

        run(6'h0d, 6'h15, -1, -1);  // ori
        run(6'h23, 6'h3a, -1, -1);  // lw
        run(6'h04, 6'h00, 1, -1);   // beq, Zero=1
        run(6'h04, 6'h00, 0, -1);   // beq, Zero=0
        run(6'h03, 6'h11, -1, -1);  // jal
        run(6'h28, 6'h00, -1, 3);   // sb, reset in MEM
        run(6'h3f, 6'h00, -1, -1);  // unsupported op
        run(6'h00, 6'h01, -1, -1);  // unsupported func
        run(6'h00, 6'h21, -1, -1);  // addu
        run(6'h00, 6'h23, -1, -1);  // subu
        run(6'h00, 6'h00, -1, -1);  // sll
        run(6'h00, 6'h08, -1, -1);  // jr
        run(6'h00, 6'h09, -1, -1);  // jalr
        run(6'h0f, 6'h00, -1, -1);  // lui
        run(6'h20, 6'h00, -1, -1);  // lb
        run(6'h2b, 6'h00, -1, -1);  // sw
        run(6'h05, 6'h00, -1, -1);  // bne
        run(6'h02, 6'h00, -1, -1);  // j
        // Counter wrap: 20 NOPs push the 4-bit counter past 15
        for (int i = 0; i < 20; i++) run(6'h3f, 6'($urandom), -1, -1);

        for (int n = 0; n < 400; n++) begin
            int         idx;
            int         ra;
            logic [5:0] o;
            logic [5:0] f;
            idx = $urandom_range(0, 15);
            if (idx == 15) begin
                o = 6'($urandom);
                f = 6'($urandom);
            end else begin
                o = top_t[idx];
                f = (o == 6'h00) ? tfn_t[idx] : 6'($urandom);
            end
            ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
            run(o, f, -1, ra);
        end

        @(negedge Clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
